// File: rtl/retrosoc_rst_seq_pkg.sv
// Shared types for the board reset sequencer: FSM states, reset-cause codes,
// and a helper that sizes counters from their terminal counts.
package retrosoc_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RC_POR  = 2'b00,
        RC_LOCK = 2'b01,
        RC_BTN  = 2'b10,
        RC_WDT  = 2'b11
    } cause_e;

    localparam int unsigned RST_CNT_W = 8;

    // Counter width for a terminal count of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/retrosoc_sync_debounce.sv
// Synchroniser chain plus debounce filter for an active-low button; emits a
// one-cycle press pulse when the debounced level falls.
module retrosoc_sync_debounce
    import retrosoc_rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic din_i,
    output logic press_o
);

    localparam int unsigned      DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   deb_q, deb_d;
    logic                   press_q, press_d;
    logic                   din_s;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din_i};
        din_s     = sync_q[SYNC_STAGES-1];
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press_d   = 1'b0;
        if (din_s != deb_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                deb_d   = din_s;
                press_d = ~din_s;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Released (1) is the safe idle level for the button path.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q    <= '1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/retrosoc_rst_seq.sv
// Board reset sequencer: waits for a stable PLL lock, holds the SoC in reset
// for a minimum window, and records the cause of each reset taken from RUN.
module retrosoc_rst_seq
    import retrosoc_rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned DEBOUNCE_CYCLES    = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned HOLD_CYCLES        = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 locked_i,
    input  logic                 btn_rst_n_i,
    input  logic                 wdt_rst_req_i,
    output logic                 soc_rst_n_o,
    output logic                 rst_busy_o,
    output logic [1:0]           rst_cause_o,
    output logic [RST_CNT_W-1:0] rst_cnt_o
);

    localparam int unsigned       LOCK_W   = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned       HOLD_W   = cnt_width(HOLD_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   soc_rst_n_q, soc_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   locked_s;
    logic                   btn_press;
    logic                   run_exit;

    retrosoc_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .din_i   (btn_rst_n_i),
        .press_o (btn_press)
    );

    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked_i};
        locked_s    = lock_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        cause_d     = cause_q;
        lock_cnt_d  = '0;
        hold_cnt_d  = '0;
        rst_cnt_d   = rst_cnt_q;
        run_exit    = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    if (lock_cnt_q == LOCK_MAX) begin
                        state_d = ST_HOLD;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (btn_press) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss outranks button, which outranks watchdog.
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    cause_d  = RC_LOCK;
                    run_exit = 1'b1;
                end else if (btn_press) begin
                    state_d  = ST_HOLD;
                    cause_d  = RC_BTN;
                    run_exit = 1'b1;
                end else if (wdt_rst_req_i) begin
                    state_d  = ST_HOLD;
                    cause_d  = RC_WDT;
                    run_exit = 1'b1;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        if (run_exit && (rst_cnt_q != '1)) begin
            rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end

        soc_rst_n_d = (state_d == ST_RUN);
        busy_d      = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_WAIT_LOCK;
            cause_q     <= RC_POR;
            lock_sync_q <= '0;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            rst_cnt_q   <= '0;
            soc_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            lock_sync_q <= lock_sync_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            soc_rst_n_q <= soc_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    assign soc_rst_n_o = soc_rst_n_q;
    assign rst_busy_o  = busy_q;
    assign rst_cause_o = cause_q;
    assign rst_cnt_o   = rst_cnt_q;

endmodule

// File: tb/tb_retrosoc_rst_seq.sv
// Directed bench for the reset sequencer: stimulus queues the expected output
// changes (edge number and values); a monitor compares every observed change.
module tb_retrosoc_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n_i, locked_i, btn_rst_n_i, wdt_rst_req_i;
    logic       soc_rst_n_o, rst_busy_o;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_cnt_o;

    typedef struct packed {
        int unsigned cyc;
        logic        soc;
        logic        busy;
        logic [1:0]  cause;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [11:0] prev  = 'x;
    logic [11:0] cur;

    retrosoc_rst_seq #(
        .SYNC_STAGES        (2),
        .DEBOUNCE_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .HOLD_CYCLES        (4)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .locked_i      (locked_i),
        .btn_rst_n_i   (btn_rst_n_i),
        .wdt_rst_req_i (wdt_rst_req_i),
        .soc_rst_n_o   (soc_rst_n_o),
        .rst_busy_o    (rst_busy_o),
        .rst_cause_o   (rst_cause_o),
        .rst_cnt_o     (rst_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int unsigned c, input logic s, input logic b,
                        input logic [1:0] ca, input logic [7:0] n);
        exp_t x;
        x.cyc = c; x.soc = s; x.busy = b; x.cause = ca; x.cnt = n;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change on the outputs must match the next queued event.
    always @(negedge clk) begin
        cur = {soc_rst_n_o, rst_busy_o, rst_cause_o, rst_cnt_o};
        if (cur !== prev) begin
            prev  = cur;
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_change: cyc=%0d got soc=%b busy=%b cause=%b cnt=%0d, want no change",
                         cyc, soc_rst_n_o, rst_busy_o, rst_cause_o, rst_cnt_o);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.soc !== soc_rst_n_o || e.busy !== rst_busy_o ||
                    e.cause !== rst_cause_o || e.cnt !== rst_cnt_o) begin
                    bad = bad + 1;
                    $display("FAIL event%0d: got cyc=%0d soc=%b busy=%b cause=%b cnt=%0d, want cyc=%0d soc=%b busy=%b cause=%b cnt=%0d",
                             total, cyc, soc_rst_n_o, rst_busy_o, rst_cause_o, rst_cnt_o,
                             e.cyc, e.soc, e.busy, e.cause, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        bad   = bad + 1;
        total = total + 1;
        $display("FAIL timeout: got cyc=%0d, want completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n_i = 1'b0; locked_i = 1'b1; btn_rst_n_i = 1'b1; wdt_rst_req_i = 1'b0;

        // Power-on: reset state on edge 1, release after three edges.
        push(1, 1'b0, 1'b1, 2'b00, 8'd0);
        tick(3);
        rst_n_i = 1'b1;
        push(cyc + 14, 1'b1, 1'b0, 2'b00, 8'd0);
        tick(20);

        // Unstable lock never reaches RUN; a steady lock does, 14 edges later.
        rst_n_i = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 2'b00, 8'd0);
        tick(1);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            locked_i = 1'b1; tick(5);
            locked_i = 1'b0; tick(5);
        end
        locked_i = 1'b1;
        push(cyc + 14, 1'b1, 1'b0, 2'b00, 8'd0);
        tick(20);

        // Short glitch ignored; long press drops reset 7 edges after first low sample.
        btn_rst_n_i = 1'b0; tick(3);
        btn_rst_n_i = 1'b1; tick(10);
        btn_rst_n_i = 1'b0;
        push(cyc + 7,  1'b0, 1'b1, 2'b10, 8'd1);
        push(cyc + 11, 1'b1, 1'b0, 2'b10, 8'd1);
        tick(10);
        btn_rst_n_i = 1'b1;
        tick(20);

        // Watchdog pulse: four cycles of reset.
        wdt_rst_req_i = 1'b1;
        push(cyc + 1, 1'b0, 1'b1, 2'b11, 8'd2);
        push(cyc + 5, 1'b1, 1'b0, 2'b11, 8'd2);
        tick(1);
        wdt_rst_req_i = 1'b0;
        tick(10);

        // Lock loss coincident with watchdog: lock loss wins, one count.
        locked_i = 1'b0;
        tick(2);
        wdt_rst_req_i = 1'b1;
        push(cyc + 1, 1'b0, 1'b1, 2'b01, 8'd3);
        tick(1);
        wdt_rst_req_i = 1'b0;
        tick(5);
        locked_i = 1'b1;
        push(cyc + 14, 1'b1, 1'b0, 2'b01, 8'd3);
        tick(20);

        // Reset mid-HOLD clears cause and count.
        wdt_rst_req_i = 1'b1;
        push(cyc + 1, 1'b0, 1'b1, 2'b11, 8'd4);
        tick(1);
        wdt_rst_req_i = 1'b0;
        tick(1);
        rst_n_i = 1'b0;
        push(cyc + 1, 1'b0, 1'b1, 2'b00, 8'd0);
        tick(1);
        rst_n_i = 1'b1;
        push(cyc + 14, 1'b1, 1'b0, 2'b00, 8'd0);
        tick(20);

        // Back-to-back watchdog resets saturate the counter at 255.
        for (int n = 1; n <= 300; n++) begin
            wdt_rst_req_i = 1'b1;
            push(cyc + 1, 1'b0, 1'b1, 2'b11, (n > 255) ? 8'd255 : 8'(n));
            push(cyc + 5, 1'b1, 1'b0, 2'b11, (n > 255) ? 8'd255 : 8'(n));
            tick(1);
            wdt_rst_req_i = 1'b0;
            tick(4);
        end
        tick(20);

        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL missing_events: got %0d unobserved, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
